// File: rtl/wb_pdm_bank.sv
// wb_pdm_bank: Wishbone-mapped bank of PWM / first-order sigma-delta outputs
// sharing one prescaled tick, each channel with a double-buffered level.
module wb_pdm_bank #(
  parameter int CHANNELS       = 4,
  parameter int BIT_RESOLUTION = 8,
  parameter int ADDR_WIDTH     = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [15:0]           wb_dat_i,
  output logic [15:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_stall_o,
  output logic [CHANNELS-1:0]   pdm_o
);

  localparam int BR = BIT_RESOLUTION;
  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = ADDR_WIDTH'(CHANNELS);
  localparam logic [ADDR_WIDTH-1:0] PRE_ADDR  = ADDR_WIDTH'(CHANNELS + 1);
  localparam logic [BR-1:0]         CNT_MAX   = '1;

  logic [BR-1:0] shadow [CHANNELS];
  logic [BR-1:0] active [CHANNELS];
  logic [BR-1:0] acc    [CHANNELS];
  logic [BR:0]   sd_sum [CHANNELS];
  logic [BR-1:0] cnt;
  logic [7:0]    prescale;
  logic [7:0]    pc;
  logic          en;
  logic          mode;
  logic          req;
  logic          wr;
  logic          ctrl_wr;
  logic          pre_wr;
  logic          tick;
  logic [15:0]   rdata;
  logic          unused_dat;

  assign req        = wb_cyc_i & wb_stb_i;
  assign wr         = req & wb_we_i;
  assign ctrl_wr    = wr && (wb_adr_i == CTRL_ADDR);
  assign pre_wr     = wr && (wb_adr_i == PRE_ADDR);
  assign tick       = en && (pc == prescale);
  assign wb_stall_o = 1'b0;
  assign unused_dat = &{1'b0, wb_dat_i};

  always_comb begin
    rdata = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (wb_adr_i == ADDR_WIDTH'(i)) rdata[BR-1:0] = shadow[i];
    end
    if (wb_adr_i == CTRL_ADDR) rdata[1:0] = {mode, en};
    if (wb_adr_i == PRE_ADDR)  rdata[7:0] = prescale;
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      sd_sum[i] = {1'b0, acc[i]} + {1'b0, active[i]};
    end
  end

  // Bus side: single-cycle ack, read data only alongside a read ack.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      prescale <= '0;
      for (int i = 0; i < CHANNELS; i++) shadow[i] <= '0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= (req && !wb_we_i) ? rdata : '0;
      if (pre_wr) prescale <= wb_dat_i[7:0];
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr && (wb_adr_i == ADDR_WIDTH'(i))) shadow[i] <= wb_dat_i[BR-1:0];
      end
    end
  end

  // A CTRL write, or the bank being disabled, restarts everything from a clean period.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      en    <= 1'b0;
      mode  <= 1'b0;
      pc    <= '0;
      cnt   <= '0;
      pdm_o <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i]    <= '0;
        active[i] <= '0;
      end
    end else if (ctrl_wr || !en) begin
      if (ctrl_wr) begin
        en   <= wb_dat_i[0];
        mode <= wb_dat_i[1];
      end
      pc    <= '0;
      cnt   <= '0;
      pdm_o <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i]    <= '0;
        active[i] <= shadow[i];
      end
    end else begin
      pc <= (pre_wr || tick) ? 8'd0 : pc + 8'd1;
      if (tick) begin
        if (!mode) begin
          cnt <= cnt + BR'(1);
          for (int i = 0; i < CHANNELS; i++) begin
            pdm_o[i] <= (active[i] > cnt);
            if (cnt == CNT_MAX) active[i] <= shadow[i];
          end
        end else begin
          for (int i = 0; i < CHANNELS; i++) begin
            pdm_o[i]  <= sd_sum[i][BR];
            acc[i]    <= sd_sum[i][BR-1:0];
            active[i] <= shadow[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_pdm_bank.sv
// tb_wb_pdm_bank: randomized self-checking bench; expected waveforms come from
// closed-form duty/density arithmetic rather than a cycle model of the RTL.
module tb_wb_pdm_bank;

  localparam int CH  = 4;
  localparam int BR  = 8;
  localparam int AW  = 4;
  localparam int PER = 1 << BR;
  localparam logic [AW-1:0] CTRL_A = AW'(CH);
  localparam logic [AW-1:0] PRE_A  = AW'(CH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cyc = 1'b0;
  logic          stb = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] adr = '0;
  logic [15:0]   dat_i = '0;
  logic [15:0]   dat_o;
  logic          ack;
  logic          stall;
  logic [CH-1:0] pdm;

  int n_cmp = 0;
  int n_bad = 0;

  wb_pdm_bank #(.CHANNELS(CH), .BIT_RESOLUTION(BR), .ADDR_WIDTH(AW)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_we_i   (we),
    .wb_adr_i  (adr),
    .wb_dat_i  (dat_i),
    .wb_dat_o  (dat_o),
    .wb_ack_o  (ack),
    .wb_stall_o(stall),
    .pdm_o     (pdm)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [AW-1:0] a, input logic [15:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_i = d;
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [15:0] d, output logic k);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    @(posedge clk);
    #1;
    d = dat_o;
    k = ack;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic test_reset;
    logic [15:0] d;
    logic        k;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({pdm, ack, dat_o, stall} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs: got pdm=%b ack=%b dat=%h stall=%b, expected all 0", pdm, ack, dat_o, stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < CH + 2; a++) begin
      bus_read(AW'(a), d, k);
      n_cmp++;
      if ({k, d} !== {1'b1, 16'h0000}) begin
        n_bad++;
        $display("[TB] FAIL reset_reg%0d: got ack=%b data=%h, expected ack=1 data=0000", a, k, d);
      end
    end
  endtask

  task automatic test_pwm;
    int          lv [CH];
    int          bad [CH];
    int          ones [CH];
    logic [15:0] d;
    logic        k;
    lv[0] = 64;
    for (int c = 1; c < CH; c++) lv[c] = $urandom_range(0, PER - 1);
    for (int c = 0; c < CH; c++) begin
      bus_write(AW'(c), 16'(lv[c]));
      bad[c] = 0;
      ones[c] = 0;
    end
    bus_read(AW'(0), d, k);
    n_cmp++;
    if ({k, d} !== {1'b1, 16'd64}) begin
      n_bad++;
      $display("[TB] FAIL pwm_readback: got ack=%b data=%0d, expected ack=1 data=64", k, d);
    end
    bus_write(CTRL_A, 16'h0001);
    for (int n = 0; n < PER; n++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < CH; c++) begin
        if (pdm[c] !== logic'(n < lv[c])) bad[c]++;
        if (pdm[c] === 1'b1) ones[c]++;
      end
    end
    for (int c = 0; c < CH; c++) begin
      n_cmp++;
      if (bad[c] !== 0) begin
        n_bad++;
        $display("[TB] FAIL pwm_pattern_ch%0d: got %0d wrong ticks, expected 0 (level %0d)", c, bad[c], lv[c]);
      end
      n_cmp++;
      if (ones[c] !== lv[c]) begin
        n_bad++;
        $display("[TB] FAIL pwm_duty_ch%0d: got %0d high ticks, expected %0d", c, ones[c], lv[c]);
      end
    end
  endtask

  task automatic test_mid_period;
    int bad = 0;
    int hi0 = 0;
    int hi1 = 0;
    bus_write(AW'(1), 16'd10);
    bus_write(CTRL_A, 16'h0001);
    fork
      begin
        for (int n = 0; n < 2 * PER; n++) begin
          @(posedge clk);
          #1;
          if (pdm[1] !== logic'((n < PER) ? (n < 10) : ((n - PER) < 200))) bad++;
          if (pdm[1] === 1'b1) begin
            if (n < PER) hi0++;
            else hi1++;
          end
        end
      end
      begin
        repeat (99) @(posedge clk);
        bus_write(AW'(1), 16'd200);
      end
    join
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("[TB] FAIL mid_period_pattern: got %0d wrong ticks, expected 0", bad);
    end
    n_cmp++;
    if ({hi0, hi1} !== {32'd10, 32'd200}) begin
      n_bad++;
      $display("[TB] FAIL mid_period_duty: got %0d/%0d high, expected 10/200", hi0, hi1);
    end
  endtask

  task automatic test_sigma_delta;
    int          lv [CH];
    int          bad [CH];
    int          ones [CH];
    logic [15:0] d;
    logic        k;
    lv[0] = 'h40;
    lv[1] = 'hFF;
    lv[2] = 0;
    lv[3] = $urandom_range(1, PER - 2);
    for (int c = 0; c < CH; c++) begin
      bus_write(AW'(c), 16'(lv[c]));
      bad[c] = 0;
      ones[c] = 0;
    end
    bus_write(CTRL_A, 16'h0003);
    for (int n = 1; n <= PER; n++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < CH; c++) begin
        if (pdm[c] !== logic'((n * lv[c]) / PER - ((n - 1) * lv[c]) / PER)) bad[c]++;
        if (pdm[c] === 1'b1) ones[c]++;
      end
    end
    for (int c = 0; c < CH; c++) begin
      n_cmp++;
      if (bad[c] !== 0) begin
        n_bad++;
        $display("[TB] FAIL sd_pattern_ch%0d: got %0d wrong ticks, expected 0 (level %0d)", c, bad[c], lv[c]);
      end
      n_cmp++;
      if (ones[c] !== lv[c]) begin
        n_bad++;
        $display("[TB] FAIL sd_density_ch%0d: got %0d ones, expected %0d", c, ones[c], lv[c]);
      end
    end
    bus_read(CTRL_A, d, k);
    n_cmp++;
    if ({k, d} !== {1'b1, 16'h0003}) begin
      n_bad++;
      $display("[TB] FAIL ctrl_readback: got ack=%b data=%h, expected ack=1 data=0003", k, d);
    end
  endtask

  task automatic test_prescale;
    int          lv [CH];
    int          bad [CH];
    int          m;
    int          late = 0;
    logic [15:0] d;
    logic        k;
    bus_write(PRE_A, 16'd3);
    bus_read(PRE_A, d, k);
    n_cmp++;
    if ({k, d} !== {1'b1, 16'd3}) begin
      n_bad++;
      $display("[TB] FAIL prescale_readback: got ack=%b data=%0d, expected ack=1 data=3", k, d);
    end
    lv[0] = $urandom_range(1, PER - 2);
    lv[1] = PER - 1;
    lv[2] = 0;
    lv[3] = $urandom_range(0, PER - 1);
    for (int c = 0; c < CH; c++) begin
      bus_write(AW'(c), 16'(lv[c]));
      bad[c] = 0;
    end
    bus_write(CTRL_A, 16'h0001);
    for (int e = 1; e <= 1040; e++) begin
      @(posedge clk);
      #1;
      m = e / 4;
      for (int c = 0; c < CH; c++) begin
        if (pdm[c] !== logic'((m != 0) && (((m - 1) % PER) < lv[c]))) bad[c]++;
      end
    end
    for (int c = 0; c < CH; c++) begin
      n_cmp++;
      if (bad[c] !== 0) begin
        n_bad++;
        $display("[TB] FAIL prescale_pattern_ch%0d: got %0d wrong cycles, expected 0", c, bad[c]);
      end
    end
    bus_write(CTRL_A, 16'h0000);
    n_cmp++;
    if (pdm !== '0) begin
      n_bad++;
      $display("[TB] FAIL disable_clear: got pdm=%b, expected 0000", pdm);
    end
    for (int e = 0; e < 40; e++) begin
      @(posedge clk);
      #1;
      if (pdm !== '0) late++;
    end
    n_cmp++;
    if (late !== 0) begin
      n_bad++;
      $display("[TB] FAIL disable_hold: got %0d nonzero cycles, expected 0", late);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] dv [4];
    int          bad_ack = 0;
    int          bad_dat = 0;
    logic [15:0] d;
    logic        k;
    for (int j = 0; j < 4; j++) dv[j] = 16'($urandom_range(0, PER - 1));
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1;
      we = (j < 4);
      adr = AW'(j % 4);
      dat_i = (j < 4) ? dv[j] : 16'hFFFF;
      @(posedge clk);
      #1;
      if (ack !== 1'b1) bad_ack++;
      if (j >= 4 && dat_o !== dv[j - 4]) bad_dat++;
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    n_cmp++;
    if (bad_ack !== 0) begin
      n_bad++;
      $display("[TB] FAIL b2b_acks: got %0d missing acks, expected 0", bad_ack);
    end
    n_cmp++;
    if (bad_dat !== 0) begin
      n_bad++;
      $display("[TB] FAIL b2b_read_data: got %0d wrong reads, expected 0", bad_dat);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({ack, dat_o} !== 17'h0) begin
      n_bad++;
      $display("[TB] FAIL b2b_idle: got ack=%b data=%h, expected ack=0 data=0000", ack, dat_o);
    end
    bus_write(AW'(15), 16'hFFFF);
    bus_read(AW'(15), d, k);
    n_cmp++;
    if ({k, d} !== {1'b1, 16'h0000}) begin
      n_bad++;
      $display("[TB] FAIL unmapped_read: got ack=%b data=%h, expected ack=1 data=0000", k, d);
    end
    bus_read(AW'(0), d, k);
    n_cmp++;
    if ({k, d} !== {1'b1, dv[0]}) begin
      n_bad++;
      $display("[TB] FAIL unmapped_write_ignored: got ack=%b data=%h, expected ack=1 data=%h", k, d, dv[0]);
    end
  endtask

  task automatic test_reset_midrun;
    logic [15:0] d;
    logic        k;
    int          late = 0;
    bus_write(PRE_A, 16'd0);
    bus_write(AW'(1), 16'(PER - 1));
    bus_write(CTRL_A, 16'h0001);
    repeat (5) @(posedge clk);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = '0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({ack, pdm[1]} !== 2'b11) begin
      n_bad++;
      $display("[TB] FAIL pre_reset_activity: got ack=%b pdm1=%b, expected 1/1", ack, pdm[1]);
    end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({pdm, ack, dat_o} !== '0) begin
      n_bad++;
      $display("[TB] FAIL async_reset: got pdm=%b ack=%b dat=%h, expected all 0", pdm, ack, dat_o);
    end
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < CH + 2; a++) begin
      bus_read(AW'(a), d, k);
      n_cmp++;
      if ({k, d} !== {1'b1, 16'h0000}) begin
        n_bad++;
        $display("[TB] FAIL post_reset_reg%0d: got ack=%b data=%h, expected ack=1 data=0000", a, k, d);
      end
    end
    for (int e = 0; e < 20; e++) begin
      @(posedge clk);
      #1;
      if (pdm !== '0) late++;
    end
    n_cmp++;
    if (late !== 0) begin
      n_bad++;
      $display("[TB] FAIL post_reset_pdm: got %0d nonzero cycles, expected 0", late);
    end
  endtask

  initial begin
    $display("[TB] starting wb_pdm_bank bench");
    test_reset();
    test_pwm();
    test_mid_period();
    test_sigma_delta();
    test_prescale();
    test_back_to_back();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_pdm_bank.md
# wb_pdm_bank

Multi-channel PWM/PDM output bank on a Wishbone B4 pipelined slave: the generalised successor of the single-channel level comparator. It provides CHANNELS outputs sharing one prescaled time base. Each channel has a glitch-free double-buffered level register. A global mode selects either period-compare PWM or first-order sigma-delta PDM. It sits between the system Wishbone interconnect and the pad drivers for audio, LED or analog-filter outputs.

## Interface
- CHANNELS, 4: number of output channels, 1..14.
- BIT_RESOLUTION, 8: level, counter and accumulator width, 1..16.
- ADDR_WIDTH, 4: word address width; CHANNELS+2 ≤ 2^ADDR_WIDTH.
- wb_clk_i  in  1  sole clock.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  ADDR_WIDTH  word address.
- wb_dat_i  in  16  write data; low BIT_RESOLUTION bits used for levels.
- wb_dat_o  out  16  read data, zero-extended.
- wb_ack_o  out  1  acknowledge.
- wb_stall_o  out  1  constant 0.
- pdm_o  out  CHANNELS  registered channel outputs, bit i = channel i.

## Operation
- Register map: addresses 0..CHANNELS-1 are shadow levels. Address CHANNELS is CTRL: bit0 EN, bit1 MODE (0 PWM, 1 sigma-delta). Address CHANNELS+1 is PRESCALE (8 bits). Other addresses: writes are ignored and reads return 0.
- A request is `wb_cyc_i & wb_stb_i`. Each request is acked exactly once. Reads return the shadow level, CTRL or PRESCALE, never the active level.
- Prescaler: an 8-bit counter pc runs 0..PRESCALE. tick=1 in cycles where pc==PRESCALE, and pc then returns to 0. PRESCALE=0 gives a tick every cycle. A PRESCALE write clears pc.
- Each channel has a shadow level (bus-written) and an active level (drives output).
- PWM mode, on each tick edge:
  - pdm_o[i] ← (active[i] > cnt), using the current cnt.
  - cnt ← cnt+1, wrapping from 2^BIT_RESOLUTION−1 to 0.
  - On the tick where cnt == max, active ← shadow for all channels simultaneously. The new level therefore takes effect from cnt=0.
  - Level 0 gives duty 0. Level L gives L high ticks per 2^BIT_RESOLUTION-tick period.
- Sigma-delta mode, on each tick edge:
  - {carry, acc[i]} ← acc[i] + active[i], computed BIT_RESOLUTION+1 wide.
  - pdm_o[i] ← carry.
  - active ← shadow.
  - Long-run density is level/2^BIT_RESOLUTION.
- EN=0:
  - pdm_o, cnt, pc and all acc are held at 0.
  - active tracks shadow every cycle.
- Any CTRL write takes effect the edge after the write:
  - cnt, pc, acc and pdm_o clear to 0.
  - active ← shadow.
  - Output restarts from a clean period.
- Outputs between ticks hold their value.

## Timing
- Reset: all of the following are 0 asynchronously:
  - shadow, active, CTRL, PRESCALE, pc, cnt, acc
  - pdm_o, wb_ack_o, wb_dat_o
- Deassertion is synchronised by the integrator. The block's first tick is the cycle after release plus PRESCALE.
- Bus:
  - wb_ack_o rises the cycle after an accepted request, for one cycle per request.
  - Back-to-back requests give back-to-back acks.
  - wb_dat_o is valid with ack and is 0 when ack is low.
  - A write updates the register on the accepting edge.
- Simultaneous events:
  - Shadow write in the same cycle as a commit: the commit takes the old shadow, and the new value commits at the next commit point.
  - CTRL write in the same cycle as a tick: the CTRL clear wins, and no tick update occurs.
- Output latency: pdm_o changes on the edge ending a tick cycle.
- Reset mid-period immediately zeroes outputs. Nothing is retained.

## Test plan
- Reset, PRESCALE=0, BIT_RESOLUTION=8, EN=1, MODE=0, level[0]=64 → 64 high ticks per 256, starting at the period after the write. Read of addr 0 returns 64 with ack one cycle after the strobe.
- Mid-period write of level[1]=200 at cnt=100 while the active level is 10 → the current period keeps duty 10/256, and the next period starts at 200/256 exactly at cnt=0.
- MODE=1, level=0x40, PRESCALE=0 → pdm_o[0] pattern 0001 repeating (1 every 4 ticks). Level 0xFF → 255 ones per 256 ticks. Level 0 → constant 0.
- PRESCALE=3 → tick every 4 cycles, and pdm_o changes only on those edges. Write EN=0 mid-run → pdm_o=0 next edge and stays 0.
- Back-to-back 4 writes then 4 reads, cyc/stb held → 8 consecutive ack cycles and correct read data. Unmapped address 0xF → ack, data 0.
- Assert wb_rst_ni low asynchronously mid-cycle during activity → pdm_o and wb_ack_o drop immediately. All registers read 0 after release.
